// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory handshake, branch resolution and MEM/WB register.
module mem_access_unit #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        MEMwreg,
  input  logic        MEMm2reg,
  input  logic        MEMwmem,
  input  logic [4:0]  MEMwn,
  input  logic [31:0] MEMaluResult,
  input  logic [31:0] MEMdi,
  input  logic [1:0]  MEMjumpType,
  input  logic [31:0] MEMjumpPc,
  input  logic        MEMzero,
  output logic        dmReq,
  output logic        dmWe,
  output logic [31:0] dmAddr,
  output logic [31:0] dmWdata,
  input  logic [31:0] dmRdata,
  input  logic        dmAck,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirectPc,
  output logic        WBwreg,
  output logic [4:0]  WBwn,
  output logic [31:0] WBdata,
  output logic        alignErr,
  output logic        busErr
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);
  state_t state;
  logic [7:0] count;
  logic abort;
  logic [31:0] loadBuf;
  logic access, aligned, misalign, taken;
  assign access = MEMwmem | MEMm2reg;
  assign aligned = MEMaluResult[1:0] == 2'b00;
  assign misalign = state == IDLE && access && !aligned;
  assign stall = state == WAIT || (state == IDLE && access && aligned);
  // reset forces the error pulses low even though state already reads IDLE
  assign alignErr = misalign && !clr;
  assign busErr = state == DONE && abort;
  assign taken = (MEMjumpType == 2'b01 && MEMzero) || (MEMjumpType == 2'b10 && !MEMzero) || MEMjumpType == 2'b11;
  assign redirect = taken && !stall;
  assign redirectPc = MEMjumpPc;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      count <= '0;
      abort <= 1'b0;
      loadBuf <= '0;
      dmReq <= 1'b0;
      dmWe <= 1'b0;
      dmAddr <= '0;
      dmWdata <= '0;
      WBwreg <= 1'b0;
      WBwn <= '0;
      WBdata <= '0;
    end else begin
      WBwreg <= stall ? 1'b0 : MEMwreg && !misalign && !busErr;
      WBwn <= stall ? 5'd0 : MEMwn;
      WBdata <= stall ? 32'd0 : (MEMm2reg ? loadBuf : MEMaluResult);
      case (state)
        IDLE: if (access && aligned) begin
          state <= WAIT;
          dmReq <= 1'b1;
          dmWe <= MEMwmem;
          dmAddr <= {MEMaluResult[31:2], 2'b00};
          dmWdata <= MEMdi;
          count <= '0;
          abort <= 1'b0;
        end
        WAIT: if (dmAck) begin
          loadBuf <= dmRdata;
          dmReq <= 1'b0;
          state <= DONE;
        end else if (count == LIMIT) begin
          abort <= 1'b1;
          loadBuf <= '0;
          dmReq <= 1'b0;
          state <= DONE;
        end else begin
          count <= count + 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized scoreboard bench for mem_access_unit.
module tb_mem_access_unit;
  localparam int TO = 15;
  logic clk = 1'b0, clr = 1'b1;
  logic MEMwreg, MEMm2reg, MEMwmem, MEMzero;
  logic [4:0] MEMwn;
  logic [31:0] MEMaluResult, MEMdi, MEMjumpPc;
  logic [1:0] MEMjumpType;
  logic dmReq, dmWe, dmAck, stall, redirect, WBwreg, alignErr, busErr;
  logic [31:0] dmAddr, dmWdata, dmRdata, redirectPc, WBdata;
  logic [4:0] WBwn;
  always #5 clk = ~clk;
  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .clr(clr), .MEMwreg(MEMwreg), .MEMm2reg(MEMm2reg), .MEMwmem(MEMwmem),
    .MEMwn(MEMwn), .MEMaluResult(MEMaluResult), .MEMdi(MEMdi), .MEMjumpType(MEMjumpType),
    .MEMjumpPc(MEMjumpPc), .MEMzero(MEMzero), .dmReq(dmReq), .dmWe(dmWe), .dmAddr(dmAddr),
    .dmWdata(dmWdata), .dmRdata(dmRdata), .dmAck(dmAck), .stall(stall), .redirect(redirect),
    .redirectPc(redirectPc), .WBwreg(WBwreg), .WBwn(WBwn), .WBdata(WBdata),
    .alignErr(alignErr), .busErr(busErr));
  typedef struct {int stalls; int reqs; bit align; bit bus; bit redir; logic [31:0] rpc; bit wreg; logic [4:0] wn; logic [31:0] data;} exp_t;
  typedef struct {bit we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; int delay; bit to;} resp_t;
  exp_t expQ[$];
  resp_t respQ[$];
  logic [31:0] memModel [logic [29:0]];
  logic [31:0] loadBufModel = 32'd0;
  int nChk = 0, nFail = 0;
  bit monEn = 0, pokeAck = 0;
  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    nChk++;
    if (act !== req) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endfunction
  task automatic setIn(input bit wreg, m2reg, wmem, input logic [4:0] wn, input logic [31:0] alu, di,
                       input logic [1:0] jt, input logic [31:0] jpc, input bit zero);
    MEMwreg = wreg; MEMm2reg = m2reg; MEMwmem = wmem; MEMwn = wn; MEMaluResult = alu;
    MEMdi = di; MEMjumpType = jt; MEMjumpPc = jpc; MEMzero = zero;
  endtask
  // Reference model: one instruction's whole MEM-stage story computed up front, then held until it leaves.
  task automatic issue(input bit wreg, m2reg, wmem, input logic [4:0] wn, input logic [31:0] alu, di,
                       input logic [1:0] jt, input logic [31:0] jpc, input bit zero, input int delay);
    exp_t e;
    resp_t r;
    bit acc, to, left;
    acc = wmem | m2reg;
    to = delay >= TO;
    e = '{stalls: 0, reqs: 0, align: 0, bus: 0, redir: 0, rpc: jpc, wreg: wreg, wn: wn, data: 0};
    e.redir = (jt == 2'b01 && zero) || (jt == 2'b10 && !zero) || jt == 2'b11;
    if (acc && alu[1:0] != 2'b00) begin
      e.align = 1;
      e.wreg = 0;
    end else if (acc) begin
      r.we = wmem; r.addr = {alu[31:2], 2'b00}; r.wdata = di; r.delay = delay; r.to = to;
      r.rdata = memModel.exists(alu[31:2]) ? memModel[alu[31:2]] : 32'd0;
      e.stalls = to ? TO + 1 : delay + 2;
      e.reqs = e.stalls - 1;
      e.bus = to;
      if (to) e.wreg = 0;
      loadBufModel = to ? 32'd0 : r.rdata;
      if (wmem && !to) memModel[alu[31:2]] = di;
      respQ.push_back(r);
    end
    e.data = m2reg ? loadBufModel : alu;
    expQ.push_back(e);
    setIn(wreg, m2reg, wmem, wn, alu, di, jt, jpc, zero);
    left = 0;
    for (int i = 0; i < 100 && !left; i++) begin
      @(negedge clk);
      left = !stall;
    end
    nChk++;
    if (!left) begin
      nFail++;
      $display("FAIL progress: stall still 1 after 100 cycles, required 0");
    end
    @(posedge clk); #1;
  endtask
  // Monitor: WB shows the result of the cycle before; each non-stalled cycle retires one instruction.
  bit wbPending = 0;
  exp_t wbExp, cur;
  int sc = 0, rc = 0;
  initial forever begin
    @(negedge clk);
    if (!monEn) begin
      wbPending = 0; sc = 0; rc = 0;
    end else begin
      chk("WBwreg", 32'(WBwreg), wbPending ? 32'(wbExp.wreg) : 32'd0);
      chk("WBwn", 32'(WBwn), wbPending ? 32'(wbExp.wn) : 32'd0);
      chk("WBdata", WBdata, wbPending ? wbExp.data : 32'd0);
      if (dmReq) rc++;
      if (stall) begin
        sc++;
        chk("redirect_stalled", 32'(redirect), 32'd0);
        chk("busErr_stalled", 32'(busErr), 32'd0);
        chk("alignErr_stalled", 32'(alignErr), 32'd0);
        wbPending = 0;
      end else if (expQ.size() == 0) begin
        nChk++; nFail++;
        $display("FAIL retire: instruction left MEM, none expected");
        wbPending = 0;
      end else begin
        cur = expQ.pop_front();
        chk("stallCycles", 32'(sc), 32'(cur.stalls));
        chk("reqCycles", 32'(rc), 32'(cur.reqs));
        chk("alignErr", 32'(alignErr), 32'(cur.align));
        chk("busErr", 32'(busErr), 32'(cur.bus));
        chk("redirect", 32'(redirect), 32'(cur.redir));
        chk("redirectPc", redirectPc, cur.rpc);
        wbExp = cur; wbPending = 1; sc = 0; rc = 0;
      end
    end
  end
  // Memory responder: acks each request after its chosen delay, or never for a timeout.
  resp_t rs;
  initial begin
    dmAck = 0;
    dmRdata = 32'd0;
    forever begin
      @(negedge clk);
      if (pokeAck) begin
        dmAck = 1; dmRdata = 32'hBAD0BAD0;
        @(posedge clk); #1 dmAck = 0;
      end else if (respQ.size() != 0 && dmReq) begin
        rs = respQ.pop_front();
        for (int k = 0; k < (rs.to ? TO : rs.delay + 1); k++) begin
          chk("dmWe", 32'(dmWe), 32'(rs.we));
          chk("dmAddr", dmAddr, rs.addr);
          chk("dmWdata", dmWdata, rs.wdata);
          if (!rs.to && k == rs.delay) begin
            dmAck = 1; dmRdata = rs.rdata;
            @(posedge clk); #1 dmAck = 0; dmRdata = $urandom;
          end else begin
            dmRdata = $urandom;
          end
          if (k < (rs.to ? TO : rs.delay + 1) - 1) @(negedge clk);
        end
      end
    end
  end
  initial begin
    int kind, dly;
    logic [31:0] a;
    bit ld;
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("rst_dmReq", 32'(dmReq), 0); chk("rst_dmWe", 32'(dmWe), 0);
    chk("rst_dmAddr", dmAddr, 0); chk("rst_dmWdata", dmWdata, 0);
    chk("rst_WBwreg", 32'(WBwreg), 0); chk("rst_WBwn", 32'(WBwn), 0); chk("rst_WBdata", WBdata, 0);
    chk("rst_alignErr", 32'(alignErr), 0); chk("rst_busErr", 32'(busErr), 0);
    setIn(1, 1, 0, 3, 32'h40, 0, 2'b11, 32'h1234, 0);
    #1 chk("rst_stall_follows", 32'(stall), 1); chk("rst_redirect_masked", 32'(redirect), 0);
    MEMaluResult = 32'h41;
    #1 chk("rst_stall_misaligned", 32'(stall), 0); chk("rst_redirect", 32'(redirect), 1);
    chk("rst_alignErr_masked", 32'(alignErr), 0);
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1 clr = 0;
    @(posedge clk); #1 monEn = 1;
    memModel[30'h4] = 32'hDEADBEEF;
    issue(1, 1, 0, 5, 32'h10, 0, 0, 0, 0, 0);
    issue(0, 0, 1, 7, 32'h20, 32'h12345678, 0, 0, 0, 3);
    issue(1, 1, 0, 9, 32'h20, 0, 0, 0, 0, TO);
    issue(1, 1, 0, 9, 32'h20, 0, 0, 0, 0, TO - 1);
    issue(1, 1, 0, 4, 32'h13, 0, 0, 0, 0, 0);
    issue(1, 0, 0, 1, 32'h5, 0, 2'b01, 32'h00400040, 1, 0);
    issue(1, 0, 0, 2, 32'h6, 0, 2'b10, 32'h00400040, 1, 0);
    issue(1, 0, 0, 3, 32'h7, 0, 2'b11, 32'h00400040, 1, 0);
    issue(1, 1, 0, 6, 32'h10, 0, 2'b11, 32'h00400080, 0, 1);
    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 9);
      dly = kind == 9 ? $urandom_range(TO - 2, TO + 1) : $urandom_range(0, 4);
      a = 32'h100 + 32'($urandom_range(0, 7)) * 4;
      ld = $urandom_range(0, 1) == 1;
      if (kind == 8) a = a + 32'($urandom_range(1, 3));
      if (kind < 4)
        issue($urandom_range(0, 1) == 1, 0, 0, 5'($urandom), $urandom, $urandom, 2'($urandom), $urandom, $urandom_range(0, 1) == 1, 0);
      else if (kind == 4 || kind == 5)
        issue(1, 1, 0, 5'($urandom), a, $urandom, 2'($urandom), $urandom, $urandom_range(0, 1) == 1, dly);
      else if (kind == 6 || kind == 7)
        issue(0, 0, 1, 5'($urandom), a, $urandom, 2'($urandom), $urandom, $urandom_range(0, 1) == 1, dly);
      else
        issue(ld, ld, !ld, 5'($urandom), a, $urandom, 2'($urandom), $urandom, $urandom_range(0, 1) == 1, dly);
    end
    monEn = 0;
    setIn(1, 1, 0, 8, 32'h40, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk); chk("clr_wait1_dmReq", 32'(dmReq), 1);
    @(negedge clk);
    clr = 1;
    #1 chk("clr_dmReq", 32'(dmReq), 0); chk("clr_dmAddr", dmAddr, 0); chk("clr_dmWe", 32'(dmWe), 0);
    chk("clr_WBwreg", 32'(WBwreg), 0); chk("clr_WBdata", WBdata, 0); chk("clr_stall", 32'(stall), 1);
    setIn(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1 chk("clr_stall_idle", 32'(stall), 0);
    @(posedge clk); #1 clr = 0; pokeAck = 1;
    @(posedge clk); #1 pokeAck = 0;
    @(negedge clk); chk("lateAck_dmReq", 32'(dmReq), 0); chk("lateAck_stall", 32'(stall), 0);
    loadBufModel = 32'd0;
    @(posedge clk); #1 monEn = 1;
    issue(1, 1, 0, 2, 32'h22, 0, 0, 0, 0, 0);
    issue(1, 1, 0, 5, 32'h10, 0, 0, 0, 0, 2);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    monEn = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nChk, nFail);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage control block of the 5-stage pipeline. It consumes the EX/MEM register outputs and drives the external data memory through a req/ack handshake. It stalls the front of the pipeline while an access is outstanding, resolves branches and jumps held in MEM, and owns the MEM/WB register that feeds write-back.

## Interface
Parameters:
- TIMEOUT, 15: maximum WAIT cycles without dmAck before the access is aborted (1..255).

Ports:
- clk  in  1  pipeline clock, all state on posedge
- clr  in  1  asynchronous, active-high reset
- MEMwreg, MEMm2reg, MEMwmem  in  1 each  control bits from EX/MEM
- MEMwn  in  5  destination register
- MEMaluResult  in  32  ALU result / byte address
- MEMdi  in  32  store data
- MEMjumpType  in  2  00 none, 01 beq, 10 bne, 11 unconditional
- MEMjumpPc  in  32  branch/jump target
- MEMzero  in  1  ALU zero flag
- dmReq  out  1  memory request, registered
- dmWe  out  1  1 = write, valid with dmReq
- dmAddr  out  32  word address (byte address, bits [1:0] forced 0)
- dmWdata  out  32  store data
- dmRdata  in  32  load data, valid with dmAck
- dmAck  in  1  one-cycle completion strobe
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM (combinational)
- redirect  out  1  taken branch/jump (combinational)
- redirectPc  out  32  equals MEMjumpPc
- WBwreg  out  1  MEM/WB write enable
- WBwn  out  5  MEM/WB destination
- WBdata  out  32  MEM/WB write-back value
- alignErr  out  1  one-cycle pulse on misaligned access
- busErr  out  1  one-cycle pulse on access timeout

## Operation
- access = MEMwmem | MEMm2reg. aligned = (MEMaluResult[1:0] == 0).
- FSM states: IDLE, WAIT, DONE.
- IDLE:
  - access & aligned -> stall=1; next WAIT; latch address, data, and we=MEMwmem; clear the timeout counter.
  - access & ~aligned -> no request, stall=0, alignErr=1 this cycle, the instruction passes to MEM/WB with wreg forced 0.
  - dmAck in IDLE is ignored.
- WAIT:
  - dmReq=1. dmWe, dmAddr and dmWdata are stable. stall=1.
  - dmAck -> capture dmRdata into the load buffer; next DONE.
  - No dmAck: counter increments. When the counter reaches TIMEOUT-1 without ack, next DONE with the abort flag set.
  - If dmAck arrives in the same cycle as the limit, ack wins.
- DONE:
  - dmReq=0, stall=0. busErr=1 if aborted.
  - EX/MEM advances at this edge. Next state is always IDLE, so the same instruction is never reissued.
- Branch: taken = (type==01 & zero) | (type==10 & ~zero) | (type==11). redirect = taken & ~stall. redirectPc = MEMjumpPc.
- MEM/WB register, updated on every posedge:
  - stall=1: load a bubble (WBwreg=0, WBwn=0, WBdata=0).
  - Otherwise: WBwreg = MEMwreg & ~alignErr & ~abort. WBwn = MEMwn. WBdata = MEMm2reg ? loadbuf : MEMaluResult.
  - An aborted load writes loadbuf=0 with WBwreg=0.

## Timing
- Reset (clr=1, async) values:
  - State IDLE, counter 0.
  - dmReq, dmWe, dmAddr and dmWdata are all 0.
  - WBwreg, WBwn and WBdata are all 0.
  - alignErr and busErr are 0. loadbuf is 0.
- stall and redirect follow the inputs combinationally under reset.
- A clr assertion in WAIT drops dmReq immediately. A late dmAck after reset is ignored.
- Access latency, ack in the first WAIT cycle: the instruction spends 3 cycles in MEM (IDLE, WAIT, DONE), with 2 stall cycles.
- Each extra ack delay cycle adds one stall cycle.
- Timeout: exactly TIMEOUT WAIT cycles, then DONE.
- Non-memory instructions: 0 stall, 1 cycle in MEM, WB outputs valid the next cycle.
- Back-to-back accesses: DONE -> IDLE -> WAIT. dmReq is deasserted for at least 2 cycles between requests.

## Test plan
- Load, addr 0x00000010, ack on first WAIT cycle, dmRdata 0xDEADBEEF, MEMwn=5 -> stall high 2 cycles, dmReq high 1 cycle with dmWe=0 and dmAddr=0x10; WBwreg=1, WBwn=5, WBdata=0xDEADBEEF one cycle after DONE.
- Store, addr 0x20, MEMdi 0x12345678, ack delayed 3 cycles -> dmWe=1, dmWdata stable for 4 WAIT cycles, stall high 5 cycles, WBwreg=0.
- Load with TIMEOUT=15 and no ack -> 15 WAIT cycles, busErr pulse in DONE, WBwreg=0, FSM back in IDLE. Repeat with ack on the 15th cycle -> no busErr, data captured.
- Load at addr 0x13 -> no dmReq, alignErr for 1 cycle, stall=0, WBwreg=0.
- beq with zero=1, bne with zero=1, jump type 11 with target 0x00400040 -> redirect = 1, 0, 1 respectively, redirectPc=0x00400040. redirect=0 whenever stall=1.
- clr pulsed in the 2nd WAIT cycle, then ack -> dmReq falls asynchronously, all outputs 0, the ack is ignored, and the next load issues normally.
